// File: rtl/npu_fifo_pkg.sv
// npu_fifo_pkg: shared types and default sizes for the NPU FIFO and its write-side arbiter
package npu_fifo_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational rotating-priority encoder returning the first set request at or after start
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] start,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);
  localparam int SW = IDX_WIDTH + 1;
  localparam logic [SW-1:0] N = SW'(NUM_REQ);
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_WIDTH-1:0] w_off;
  logic [SW-1:0]        w_sum;
  // rotate so that bit 0 is the request at start, then find the lowest set bit
  assign w_rot = NUM_REQ'({req, req} >> start);
  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) w_off = w_rot[k] ? IDX_WIDTH'(k) : w_off;
  end
  assign w_sum = {1'b0, start} + {1'b0, w_off};
  assign found = |req;
  assign idx = (w_sum >= N) ? IDX_WIDTH'(w_sum - N) : w_sum[IDX_WIDTH-1:0];
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter
  import npu_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int NUM_REQ = 4,
  parameter int REQ_IDX_WIDTH = 2,
  parameter int MAX_BURST = 4,
  parameter int BURST_CNT_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [REQ_IDX_WIDTH-1:0]      grant_id
);
  localparam logic [REQ_IDX_WIDTH-1:0]   LAST_IDX = REQ_IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [BURST_CNT_WIDTH-1:0] CNT_MAX = BURST_CNT_WIDTH'(MAX_BURST - 1);
  arb_state_t                 r_state, w_next;
  logic [REQ_IDX_WIDTH-1:0]   r_grant_id, r_last_grant, w_start, w_idx;
  logic [BURST_CNT_WIDTH-1:0] r_beat_cnt;
  logic                       w_found, w_in_burst, w_g_valid, w_end;

  assign w_start = (r_last_grant == LAST_IDX) ? '0 : r_last_grant + REQ_IDX_WIDTH'(1);
  rr_priority_picker #(.NUM_REQ(NUM_REQ), .IDX_WIDTH(REQ_IDX_WIDTH)) u_picker (
    .req  (req_valid),
    .start(w_start),
    .found(w_found),
    .idx  (w_idx)
  );
  assign w_in_burst = r_state == BURST;
  assign w_g_valid = req_valid[r_grant_id];
  // a dropped valid ends the burst at once; a full FIFO only stalls it
  assign w_end = w_in_burst && (!w_g_valid || (fifo_wr && (req_last[r_grant_id] || r_beat_cnt == CNT_MAX)));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb w_next = w_in_burst ? (w_end ? IDLE : BURST) : (w_found ? BURST : IDLE);

  always_comb begin
    fifo_wr = w_in_burst && w_g_valid && !fifo_full && !rst;
    fifo_data_in = fifo_wr ? req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    req_ready = (w_in_burst && !fifo_full && !rst) ? (NUM_REQ'(1) << r_grant_id) : '0;
    grant_valid = w_in_burst;
    grant_id = r_grant_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_id <= '0;
      r_last_grant <= LAST_IDX;
      r_beat_cnt <= '0;
    end else begin
      if (!w_in_burst && w_found) r_grant_id <= w_idx;
      if (w_end) begin
        r_last_grant <= r_grant_id;
        r_beat_cnt <= '0;
      end else if (fifo_wr) r_beat_cnt <= r_beat_cnt + BURST_CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with producer queues, a FIFO model and a transaction-level arbitration model
module tb_fifo_wr_arbiter;
  import npu_fifo_pkg::*;
  localparam int NR = 4;
  localparam int DW = FIFO_DATA_WIDTH;
  localparam int MB = 4;
  typedef struct packed {logic l; logic [DW-1:0] d;} beat_t;
  typedef struct packed {logic [1:0] id; logic [DW-1:0] d;} exp_t;

  logic clk = 0, rst = 1;
  logic [NR-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [NR*DW-1:0] req_data = '0;
  logic fifo_full = 0, fifo_wr, grant_valid;
  logic [DW-1:0] fifo_data_in;
  logic [1:0] grant_id;
  int tests = 0, fails = 0, wr_total = 0, m_last = NR - 1, rd_mode = 0;
  bit rd_once = 0, rd_now = 0;
  beat_t dq[NR][$];
  beat_t mq[NR][$];
  exp_t exp_q[$];
  logic [DW-1:0] fifo_q[$];

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .REQ_IDX_WIDTH(2), .MAX_BURST(MB), .BURST_CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data_in(fifo_data_in),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // producers and FIFO: sample handshakes before the edge, update just after it
  initial begin
    logic [NR-1:0] s_acc;
    logic s_wr;
    logic [DW-1:0] s_din;
    forever begin
      @(negedge clk);
      s_acc = req_valid & req_ready;
      s_wr = fifo_wr;
      s_din = fifo_data_in;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (s_acc[i] && dq[i].size() > 0) void'(dq[i].pop_front());
      if (rd_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (s_wr) fifo_q.push_back(s_din);
      rd_now = rd_once || rd_mode == 2 || (rd_mode == 1 && $urandom_range(1, 0) == 1);
      rd_once = 0;
      fifo_full = fifo_q.size() >= FIFO_DEPTH;
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = dq[i].size() > 0;
        req_data[i*DW +: DW] = req_valid[i] ? dq[i][0].d : DW'($urandom);
        req_last[i] = req_valid[i] ? dq[i][0].l : 1'($urandom_range(1, 0));
      end
    end
  end

  // monitor: every write must be the next expected beat; ready only toward the grant
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fifo_wr) begin
          wr_total++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got id %0d data %0h expected no write", grant_id, fifo_data_in);
          end else begin
            e = exp_q.pop_front();
            chk("write", 64'({fifo_full, grant_id, fifo_data_in}), 64'({1'b0, e.id, e.d}));
          end
        end
        chk("ready_mask", 64'(req_ready), grant_valid ? 64'({3'b0, !fifo_full} << grant_id) : 64'(0));
      end
    end
  end

  task automatic load(input int i, input int n, input int tag, input int last_at, input bit rnd);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = {8'(i), 8'(tag), 16'(k + 1)};
      b.l = rnd ? ($urandom_range(3, 0) == 0) : (k == last_at);
      dq[i].push_back(b);
      mq[i].push_back(b);
    end
  endtask

  // expected write order from round-robin rules over whole producer queues
  task automatic model_run();
    beat_t b;
    int p;
    while (1) begin
      p = -1;
      for (int k = 1; k <= NR; k++) if (p < 0 && mq[(m_last + k) % NR].size() > 0) p = (m_last + k) % NR;
      if (p < 0) break;
      for (int n = 0; n < MB && mq[p].size() > 0; n++) begin
        b = mq[p].pop_front();
        exp_q.push_back(exp_t'({2'(p), b.d}));
        if (b.l) break;
      end
      m_last = p;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (dq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input string name);
    int c = 0;
    while (c < 3000 && !(all_empty() && exp_q.size() == 0 && !grant_valid)) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk({name, "_done"}, 64'(c < 3000), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1;
    for (int i = 0; i < NR; i++) begin
      dq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    m_last = NR - 1;
  endtask

  initial begin
    int c, w0;
    logic [DW-1:0] v;
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    chk("reset_outputs", 64'({grant_valid, grant_id, fifo_wr, fifo_data_in, req_ready}), 64'(0));
    @(posedge clk);
    #2;
    load(0, 4, 0, 3, 0);
    model_run();
    repeat (2) @(negedge clk);
    chk("t1_bubble", 64'({grant_valid, fifo_wr}), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_beat", 64'({fifo_wr, grant_valid, grant_id}), 64'({1'b1, 1'b1, 2'd0}));
    end
    @(negedge clk);
    chk("t1_released", 64'(grant_valid), 64'(0));
    wait_idle("t1");
    chk("t1_fifo_n", 64'(fifo_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      v = (fifo_q.size() > 0) ? fifo_q.pop_front() : 'x;
      chk("t1_fifo_rd", 64'(v), 64'(k + 1));
    end
    do_reset();
    rd_mode = 2;
    for (int i = 0; i < NR; i++) load(i, 6, 2, -1, 0);
    model_run();
    chk("t2_expected_beats", 64'(exp_q.size()), 64'd24);
    wait_idle("t2");
    rd_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    fifo_q.delete();
    @(posedge clk);
    #2;
    w0 = wr_total;
    load(2, 12, 3, -1, 0);
    model_run();
    c = 0;
    while (!fifo_full && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t3_full_seen", 64'(fifo_full), 64'd1);
    chk("t3_fill_count", 64'(wr_total - w0), 64'd8);
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      chk("t3_stall", 64'({req_ready[2], fifo_wr, grant_valid, grant_id}), 64'({1'b0, 1'b0, 1'b1, 2'd2}));
    end
    w0 = wr_total;
    @(posedge clk);
    #2;
    rd_once = 1;
    repeat (6) @(negedge clk);
    chk("t3_one_release", 64'(wr_total - w0), 64'd1);
    chk("t3_full_again", 64'(fifo_full), 64'd1);
    rd_mode = 2;
    wait_idle("t3");
    load(3, 1, 4, 0, 0);
    model_run();
    wait_idle("t4_pre");
    load(1, 2, 4, -1, 0);
    model_run();
    repeat (2) @(posedge clk);
    #2;
    load(3, 3, 5, -1, 0);
    load(0, 3, 5, -1, 0);
    model_run();
    wait_idle("t4");
    load(1, 4, 6, 3, 0);
    mq[1].delete();
    exp_q.push_back(exp_t'({2'd1, 8'd1, 8'd6, 16'd1}));
    repeat (3) @(posedge clk);
    #2;
    rst = 1;
    dq[1].delete();
    @(negedge clk);
    chk("t5_rst_no_wr", 64'(fifo_wr), 64'(0));
    @(posedge clk);
    #2;
    rst = 0;
    m_last = NR - 1;
    @(negedge clk);
    chk("t5_reset_outputs", 64'({grant_valid, grant_id, fifo_wr, fifo_data_in, req_ready}), 64'(0));
    chk("t5_partial_dropped", 64'(exp_q.size()), 64'd0);
    load(3, 2, 7, -1, 0);
    load(0, 2, 7, -1, 0);
    model_run();
    wait_idle("t5");
    load(1, 3, 8, 0, 0);
    load(2, 2, 8, -1, 0);
    model_run();
    wait_idle("t6");
    for (int r = 0; r < 30; r++) begin
      rd_mode = $urandom_range(2, 1);
      for (int i = 0; i < NR; i++) load(i, $urandom_range(8, 0), 16 + r, -1, 1);
      model_run();
      wait_idle("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
